// File: rtl/serial_arith_pkg.sv
// Shared types and helpers for the bit-serial word adder.
//   state_e  : word-level FSM states
//   OP_ADD / OP_SUB : encodings of the sub operand-select input
//   clog2    : bit-count counter width
//   maj3     : carry (majority) function of a one-bit full adder
package serial_arith_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StDone
    } state_e;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    function automatic int unsigned clog2(input int unsigned value);
        return $clog2(value);
    endfunction

    function automatic logic maj3(input logic x, input logic y, input logic z);
        return (x & y) | (x & z) | (y & z);
    endfunction

endpackage

// File: rtl/serial_word_adder_if.sv
// Handshake/data bundle of serial_word_adder.
//   Operand side : in_valid, in_ready, a, b, cin, sub
//   Result side  : out_valid, out_ready, sum, cout
//   Debug        : bit_s (current serial sum bit), bit_valid (high while shifting)
// master = producer/consumer environment, slave = the adder.
interface serial_word_adder_if #(
    parameter int unsigned WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             bit_s;
    logic             bit_valid;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, bit_s, bit_valid
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, bit_s, bit_valid
    );

endinterface

// File: rtl/serial_fa_stage.sv
// One-bit full adder with a registered carry.
//   clk, reset     : clock, synchronous active-high reset (clears carry)
//   load, load_val : preset carry to load_val (takes priority over en)
//   en             : advance carry to majority(a_bit, b_bit, carry)
//   a_bit, b_bit   : operand bits of the current cycle
//   s              : combinational sum bit
//   carry          : registered carry
module serial_fa_stage
    import serial_arith_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic load_val,
    input  logic en,
    input  logic a_bit,
    input  logic b_bit,
    output logic s,
    output logic carry
);

    logic carry_q, carry_d;

    always_comb begin
        carry_d = carry_q;
        if (load) begin
            carry_d = load_val;
        end else if (en) begin
            carry_d = maj3(a_bit, b_bit, carry_q);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            carry_q <= 1'b0;
        end else begin
            carry_q <= carry_d;
        end
    end

    assign s     = a_bit ^ b_bit ^ carry_q;
    assign carry = carry_q;

endmodule

// File: rtl/serial_word_adder.sv
// Word-level wrapper around a bit-serial full adder. Accepts two WIDTH-bit
// operands, streams them LSB-first through serial_fa_stage over WIDTH cycles,
// and presents the collected sum and carry-out. Subtraction is a + ~b + ~cin.
//   clk, reset : clock, synchronous active-high reset
//   bus        : serial_word_adder_if slave (operand handshake, result
//                handshake, serial debug bits)
module serial_word_adder
    import serial_arith_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    serial_word_adder_if.slave   bus
);

    localparam int unsigned CntW = clog2(WIDTH);
    localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    // Only WIDTH-1 sum bits need storing: the last bit goes straight into sum.
    logic [WIDTH-2:0] sum_sh_q, sum_sh_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;

    logic [WIDTH-1:0] sum_next;
    logic             fa_load, fa_load_val, fa_en, fa_s, fa_carry;

    serial_fa_stage u_fa (
        .clk      (clk),
        .reset    (reset),
        .load     (fa_load),
        .load_val (fa_load_val),
        .en       (fa_en),
        .a_bit    (a_sh_q[0]),
        .b_bit    (b_sh_q[0]),
        .s        (fa_s),
        .carry    (fa_carry)
    );

    always_comb begin
        state_d     = state_q;
        a_sh_d      = a_sh_q;
        b_sh_d      = b_sh_q;
        sum_sh_d    = sum_sh_q;
        cnt_d       = cnt_q;
        sum_d       = sum_q;
        cout_d      = cout_q;
        fa_load     = 1'b0;
        fa_load_val = 1'b0;
        fa_en       = 1'b0;
        sum_next    = {fa_s, sum_sh_q};

        unique case (state_q)
            StIdle: begin
                if (bus.in_valid) begin
                    a_sh_d      = bus.a;
                    b_sh_d      = (bus.sub == OP_SUB) ? ~bus.b : bus.b;
                    fa_load     = 1'b1;
                    fa_load_val = (bus.sub == OP_SUB) ? ~bus.cin : bus.cin;
                    cnt_d       = '0;
                    state_d     = StShift;
                end
            end
            StShift: begin
                fa_en    = 1'b1;
                sum_sh_d = sum_next[WIDTH-1:1];
                a_sh_d   = a_sh_q >> 1;
                b_sh_d   = b_sh_q >> 1;
                cnt_d    = cnt_q + CntW'(1);
                if (cnt_q == CntLast) begin
                    sum_d   = sum_next;
                    // Carry out of the final bit, before the stage register updates.
                    cout_d  = maj3(a_sh_q[0], b_sh_q[0], fa_carry);
                    state_d = StDone;
                end
            end
            StDone: begin
                if (bus.out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            sum_sh_q <= '0;
            cnt_q    <= '0;
            sum_q    <= '0;
            cout_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            sum_sh_q <= sum_sh_d;
            cnt_q    <= cnt_d;
            sum_q    <= sum_d;
            cout_q   <= cout_d;
        end
    end

    assign bus.in_ready  = (state_q == StIdle) && !reset;
    assign bus.out_valid = (state_q == StDone);
    assign bus.bit_valid = (state_q == StShift);
    assign bus.bit_s     = (state_q == StShift) ? fa_s : 1'b0;
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;

endmodule
